// File: rtl/hilo_seq_pkg.sv
// hilo_seq_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - MD_OP_* operation codes presented by the execute stage
//   - HS_* sequencer state encoding
//   - WORD/DWORD widths of the HI/LO resource
package hilo_seq_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWORD_W = 2 * WORD_W;
    localparam int unsigned OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5,
        MD_OP_MFHI  = 3'd6,
        MD_OP_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_MUL  = 2'd1,
        HS_DIV  = 2'd2,
        HS_FIX  = 2'd3
    } hs_state_e;

endpackage

// File: rtl/hilo_step.sv
// hilo_step: one combinational iteration of the shared HI/LO datapath.
//   is_div=0: shift-add multiply step on {acc, opnd}; opnd holds the multiplier,
//             m the multiplicand.
//   is_div=1: restoring divide step on {acc, opnd}; acc is the partial
//             remainder, opnd shifts the dividend out and the quotient in,
//             m is the divisor.
// Ports: is_div, acc, opnd, m in; acc_nxt, opnd_nxt out.
module hilo_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] opnd_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;

    // Single step: add-then-shift-right for multiply, shift-left-then-subtract for divide
    always_comb begin
        sum    = {1'b0, acc} + (opnd[0] ? {1'b0, m} : '0);
        rem_sh = {acc, opnd[XLEN-1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, m}) begin
                acc_nxt  = XLEN'(rem_sh - {1'b0, m});
                opnd_nxt = {opnd[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt  = rem_sh[XLEN-1:0];
                opnd_nxt = {opnd[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt  = sum[XLEN:1];
            opnd_nxt = {sum[0], opnd[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_seq.sv
// hilo_seq: multi-cycle sequencer owning the architectural HI/LO register.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO only in IDLE; multiply and
// divide run one bit per cycle through hilo_step, then FIX applies the sign
// correction and writes HI/LO.
// Ports:
//   clk_cpu, reset (async, active-low)
//   op_valid, op, rs, rt, flush      : request from execute
//   op_ready, stall                  : accept / pipeline hold
//   rd_data                          : MFHI/MFLO result in the accept cycle
//   busy, hilo_q                     : in-progress flag, {HI, LO}
// Build option: HILO_FAST_MULT_EN selects a single-cycle combinational
// multiply for MULT/MULTU (divide stays iterative).
module hilo_seq
    import hilo_seq_pkg::*;
#(
    parameter int unsigned XLEN = WORD_W
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   rs,
    input  logic [XLEN-1:0]   rt,
    input  logic              flush,
    output logic              op_ready,
    output logic              stall,
    output logic [XLEN-1:0]   rd_data,
    output logic              busy,
    output logic [2*XLEN-1:0] hilo_q
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned HW    = 2 * XLEN;

    hs_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic              is_div_q, is_div_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              busy_q, busy_d;
    logic [HW-1:0]     hilo_d;

    logic              accept;
    logic              is_mul_op, is_div_op, is_signed_op;
    logic              rs_neg, rt_neg, div_zero;
    logic [XLEN-1:0]   rs_abs, rt_abs;
    logic [XLEN-1:0]   step_acc, step_opnd;
    logic [HW-1:0]     fix_res;
`ifdef HILO_FAST_MULT_EN
    logic [HW-1:0]     fast_prod;
    logic [HW-1:0]     fast_res;
`endif

    // flush blocks acceptance even in IDLE
    assign accept = op_valid && (state_q == HS_IDLE) && !flush;
    assign busy   = busy_q;

    // Operand decode: magnitudes and signs for the signed ops
    always_comb begin
        is_mul_op    = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
        is_div_op    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
        is_signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
        rs_neg       = is_signed_op && rs[XLEN-1];
        rt_neg       = is_signed_op && rt[XLEN-1];
        rs_abs       = rs_neg ? (~rs + XLEN'(1)) : rs;
        rt_abs       = rt_neg ? (~rt + XLEN'(1)) : rt;
        div_zero     = (rt == '0);
    end

    // FIX-stage result: negate product, or quotient/remainder independently
    always_comb begin
        if (is_div_q) begin
            fix_res = {(rsign_q ? (~acc_q + XLEN'(1)) : acc_q),
                       (qsign_q ? (~opnd_q + XLEN'(1)) : opnd_q)};
        end else begin
            fix_res = qsign_q ? (~{acc_q, opnd_q} + HW'(1)) : {acc_q, opnd_q};
        end
    end

`ifdef HILO_FAST_MULT_EN
    // Single-cycle magnitude multiply with sign applied afterwards
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, rs_abs} * {{XLEN{1'b0}}, rt_abs};
        fast_res  = (rs_neg ^ rt_neg) ? (~fast_prod + HW'(1)) : fast_prod;
    end
`endif

    hilo_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .m        (m_q),
        .acc_nxt  (step_acc),
        .opnd_nxt (step_opnd)
    );

    // State register
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = HS_IDLE;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    if (accept && is_mul_op) begin
`ifdef HILO_FAST_MULT_EN
                        state_d = HS_IDLE;
`else
                        state_d = HS_MUL;
`endif
                    end else if (accept && is_div_op) begin
                        state_d = div_zero ? HS_FIX : HS_DIV;
                    end
                end
                HS_MUL, HS_DIV: begin
                    if (cnt_q == '0) begin
                        state_d = HS_FIX;
                    end
                end
                HS_FIX:  state_d = HS_IDLE;
                default: state_d = HS_IDLE;
            endcase
        end
    end

    // Outputs and datapath next values
    always_comb begin
        op_ready = (state_q == HS_IDLE) && !flush;
        stall    = op_valid && !op_ready;
        rd_data  = '0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        hilo_d   = hilo_q;
        busy_d   = (state_d != HS_IDLE);

        case (state_q)
            HS_IDLE: begin
                if (accept) begin
                    case (op)
                        MD_OP_MTHI: hilo_d[HW-1:XLEN]  = rs;
                        MD_OP_MTLO: hilo_d[XLEN-1:0]   = rs;
                        MD_OP_MFHI: rd_data            = hilo_q[HW-1:XLEN];
                        MD_OP_MFLO: rd_data            = hilo_q[XLEN-1:0];
                        MD_OP_MULT, MD_OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                            hilo_d   = fast_res;
`else
                            acc_d    = '0;
                            opnd_d   = rt_abs;
                            m_d      = rs_abs;
                            cnt_d    = CNT_W'(XLEN - 1);
                            is_div_d = 1'b0;
                            qsign_d  = rs_neg ^ rt_neg;
                            rsign_d  = 1'b0;
`endif
                        end
                        default: begin
                            is_div_d = 1'b1;
                            if (div_zero) begin
                                // FIX passes these through unsigned: HI=rs, LO=all ones
                                acc_d   = rs;
                                opnd_d  = '1;
                                m_d     = '0;
                                cnt_d   = '0;
                                qsign_d = 1'b0;
                                rsign_d = 1'b0;
                            end else begin
                                acc_d   = '0;
                                opnd_d  = rs_abs;
                                m_d     = rt_abs;
                                cnt_d   = CNT_W'(XLEN - 1);
                                qsign_d = rs_neg ^ rt_neg;
                                rsign_d = rs_neg;
                            end
                        end
                    endcase
                end
            end
            HS_MUL, HS_DIV: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    acc_d  = step_acc;
                    opnd_d = step_opnd;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            HS_FIX: begin
                if (!flush) begin
                    hilo_d = fix_res;
                end
            end
            default: ;
        endcase
    end

    // Datapath and architectural HI/LO registers
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            busy_q   <= 1'b0;
            hilo_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            busy_q   <= busy_d;
            hilo_q   <= hilo_d;
        end
    end

endmodule
